ram_port_arbiter: RTL and testbench

// Shares one single-port synchronous RAM (1-cycle read latency) between two requesters: port 0 (CPU)
// and port 1 (loader/debug/DMA). One access is granted per cycle, round-robin, with an optional

---
 rtl/ram_port_arbiter_if.sv | 52 +++++
 rtl/ram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the two requester ports and the RAM-side port of ram_port_arbiter.
//   m0_*  : port 0 (CPU) request, write data, lock, grant, read return
//   m1_*  : port 1 (loader/debug/DMA), same as port 0 without lock
//   ram_* : single-port synchronous RAM, read data one cycle after address
// Modports:
//   slave  : the arbiter's view (requests in, grants/RAM controls out)
//   master : the environment's view (requesters plus RAM)
interface ram_port_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between port 0
// (CPU) and port 1 (loader/debug/DMA). One access per cycle, round-robin on
// contention, with a bounded lock letting port 0 run back-to-back accesses.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous reset, active-high; also forces all grants/RAM
//          controls and read returns to 0 while asserted
//   bus  : ram_port_arbiter_if.slave (requesters + RAM)
// Parameters: AW address width, DW data width, LOCK_MAX max lock-held grants.
module ram_port_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     bus
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

  lock_state_e   lock_state_q, lock_state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_winner_q, last_winner_d;
  logic          pend_valid_q, pend_valid_d;
  logic          pend_owner_q, pend_owner_d;

  logic          gnt0, gnt1;
  logic          lock_timeout, lock_hold;
  logic [AW-1:0] addr_mux;
  logic          we_mux;
  logic [DW-1:0] wdata_mux;
  logic          rvalid0, rvalid1;

  always_comb begin
    // At the limit the lock is ignored for exactly one arbitration.
    lock_timeout = (lock_state_q == LOCK_HELD) && (lock_cnt_q == CW'(LOCK_MAX));
    // The lock only holds while port 0 keeps both req and lock asserted.
    lock_hold    = (lock_state_q == LOCK_HELD) && bus.m0_req && bus.m0_lock
                   && !lock_timeout;

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      // last_winner_q=1 means port 0 has priority on a tie.
      if (bus.m0_req && (!bus.m1_req || lock_hold || last_winner_q))
        gnt0 = 1'b1;
      else if (bus.m1_req)
        gnt1 = 1'b1;
    end

    addr_mux  = '0;
    we_mux    = 1'b0;
    wdata_mux = '0;
    if (gnt0) begin
      addr_mux  = bus.m0_addr;
      we_mux    = bus.m0_we;
      wdata_mux = bus.m0_wdata;
    end else if (gnt1) begin
      addr_mux  = bus.m1_addr;
      we_mux    = bus.m1_we;
      wdata_mux = bus.m1_wdata;
    end

    last_winner_d = last_winner_q;
    if (gnt0) last_winner_d = 1'b0;
    if (gnt1) last_winner_d = 1'b1;

    lock_state_d = LOCK_IDLE;
    lock_cnt_d   = '0;
    if (lock_timeout) begin
      lock_state_d = LOCK_IDLE;
      lock_cnt_d   = '0;
    end else if (lock_hold) begin
      lock_state_d = LOCK_HELD;
      lock_cnt_d   = (lock_cnt_q < CW'(LOCK_MAX)) ? lock_cnt_q + CW'(1) : lock_cnt_q;
    end else if (gnt0 && bus.m0_lock) begin
      lock_state_d = LOCK_HELD;
      lock_cnt_d   = CW'(1);
    end

    // Remember who owns the read data that the RAM returns next cycle.
    pend_valid_d = (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);
    pend_owner_d = gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q  <= LOCK_IDLE;
      lock_cnt_q    <= '0;
      last_winner_q <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_owner_q  <= 1'b0;
    end else begin
      lock_state_q  <= lock_state_d;
      lock_cnt_q    <= lock_cnt_d;
      last_winner_q <= last_winner_d;
      pend_valid_q  <= pend_valid_d;
      pend_owner_q  <= pend_owner_d;
    end
  end

  // A read granted just before reset must not return during reset.
  assign rvalid0 = pend_valid_q && !pend_owner_q && !rst;
  assign rvalid1 = pend_valid_q &&  pend_owner_q && !rst;

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_we    = we_mux;
  assign bus.ram_wdata = wdata_mux;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_rdata  = rvalid0 ? bus.ram_rdata : '0;
  assign bus.m1_rdata  = rvalid1 ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW       = 14;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 8;

  typedef struct packed {
    logic          g0;
    logic          g1;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gexp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } rexp_t;

  logic clk;
  logic rst;
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  gexp_t gq[$];
  rexp_t rq[$];
  logic [11:0] hist = '0;

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    return ({{(DW-AW){1'b0}}, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Environment RAM: unwritten words read back as seed(addr).
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  bit            ram_wr  [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram_mem[bus.ram_addr] <= bus.ram_wdata;
      ram_wr[bus.ram_addr]  <= 1'b1;
    end
    bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : seed(bus.ram_addr);
  end

  // Reference model state
  logic [DW-1:0] ref_mem [int];
  int m_last = 1;
  int m_run  = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed(a);
  endfunction

  // Per-port request currently being held by each requester.
  logic          p0_req = 0, p0_we = 0, p0_lk = 0;
  logic [AW-1:0] p0_a = '0;
  logic [DW-1:0] p0_d = '0;
  logic          p1_req = 0, p1_we = 0;
  logic [AW-1:0] p1_a = '0;
  logic [DW-1:0] p1_d = '0;
  bit            in_rst = 1;

  task automatic step();
    gexp_t e;
    int    w;
    @(posedge clk); #1;
    cyc++;
    rst = in_rst;
    if (in_rst) begin
      p0_req = 0;
      p1_req = 0;
    end
    bus.m0_req = p0_req; bus.m0_we = p0_we; bus.m0_lock = p0_lk;
    bus.m0_addr = p0_a;  bus.m0_wdata = p0_d;
    bus.m1_req = p1_req; bus.m1_we = p1_we;
    bus.m1_addr = p1_a;  bus.m1_wdata = p1_d;
    e = '0;
    w = -1;
    if (in_rst) begin
      rq.delete();
      m_last = 1;
      m_run  = 0;
    end else begin
      if (p0_req && p1_req)
        w = (m_run > 0 && m_run < LOCK_MAX && p0_lk) ? 0 : 1 - m_last;
      else if (p0_req) w = 0;
      else if (p1_req) w = 1;
      if (w == 0) begin e.g0 = 1; e.we = p0_we; e.addr = p0_a; e.wdata = p0_d; end
      if (w == 1) begin e.g1 = 1; e.we = p1_we; e.addr = p1_a; e.wdata = p1_d; end
      if (w >= 0) begin
        if (e.we) ref_mem[int'(e.addr)] = e.wdata;
        else      rq.push_back('{port: w, data: ref_rd(e.addr), due: cyc + 1});
        m_last = w;
      end
      if (m_run == LOCK_MAX)       m_run = 0;
      else if (w == 0 && p0_lk)    m_run = m_run + 1;
      else                         m_run = 0;
      if (w == 0) p0_req = 0;
      if (w == 1) p1_req = 0;
    end
    gq.push_back(e);
  endtask

  task automatic do_reset();
    in_rst = 1;
    step();
    in_rst = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 31));
  endfunction

  task automatic new0(input bit we, input bit lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req = 1; p0_we = we; p0_lk = lk; p0_a = a; p0_d = d;
  endtask

  task automatic new1(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req = 1; p1_we = we; p1_a = a; p1_d = d;
  endtask

  // Monitor: compares each cycle's arbitration and every read return.
  always @(negedge clk) begin
    gexp_t e, a;
    rexp_t r;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      a = '{bus.m0_gnt, bus.m1_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL grant cyc=%0d got g0=%b g1=%b we=%b addr=%h wd=%h want g0=%b g1=%b we=%b addr=%h wd=%h",
                 cyc, a.g0, a.g1, a.we, a.addr, a.wdata, e.g0, e.g1, e.we, e.addr, e.wdata);
      end
    end
    hist = {hist[10:0], bus.m1_gnt};
    if (bus.m0_rvalid || bus.m1_rvalid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rvalid cyc=%0d got rvalid0=%b rvalid1=%b want none", cyc, bus.m0_rvalid, bus.m1_rvalid);
      end else begin
        r = rq.pop_front();
        if (r.due != cyc || (bus.m0_rvalid && bus.m1_rvalid) ||
            (r.port == 0 && (!bus.m0_rvalid || bus.m0_rdata !== r.data)) ||
            (r.port == 1 && (!bus.m1_rvalid || bus.m1_rdata !== r.data))) begin
          errors++;
          $display("FAIL rdata cyc=%0d got v0=%b d0=%h v1=%b d1=%h want port=%0d data=%h due=%0d",
                   cyc, bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, bus.m1_rdata, r.port, r.data, r.due);
        end else begin
          $display("read cyc=%0d port=%0d data=%h", cyc, r.port, r.data);
        end
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      checks++;
      errors++;
      r = rq.pop_front();
      $display("FAIL missing_read cyc=%0d got no rvalid want port=%0d data=%h", cyc, r.port, r.data);
    end
    checks++;
    if ((!bus.m0_rvalid && bus.m0_rdata !== '0) || (!bus.m1_rvalid && bus.m1_rdata !== '0)) begin
      errors++;
      $display("FAIL rdata_idle cyc=%0d got d0=%h d1=%h want 0", cyc, bus.m0_rdata, bus.m1_rdata);
    end
  end

  initial begin
    rst = 1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    repeat (2) step();
    in_rst = 0;

    // Simultaneous reads after reset
    new0(0, 0, 14'h010, '0);
    new1(0, 14'h020, '0);
    repeat (4) step();

    // Continuous contention alternates
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (!p0_req) new0(0, 0, rand_addr(), '0);
      if (!p1_req) new1(0, rand_addr(), '0);
      step();
    end
    step();

    // Write through port 1 then read through port 0 at top address
    do_reset();
    new1(1, 14'h3FFF, 32'hDEAD_BEEF);
    step();
    new0(0, 0, 14'h3FFF, '0);
    repeat (3) step();

    // Lock: 8 consecutive m0 grants, one m1 grant, then m0 re-locks
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (!p0_req) new0(0, 1, AW'(i), '0);
      if (!p1_req) new1(0, AW'(100 + i), '0);
      step();
    end
    @(negedge clk); #1;
    checks++;
    if (hist !== 12'b0000_0000_1000) begin
      errors++;
      $display("FAIL lock_pattern got m1_gnt history %b want %b", hist, 12'b0000_0000_1000);
    end
    p0_lk = 0;

    // Reset right after a read grant suppresses the return
    do_reset();
    new0(0, 0, 14'h010, '0);
    step();
    in_rst = 1;
    repeat (2) step();
    in_rst = 0;
    repeat (2) step();

    // Idle
    repeat (5) step();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      in_rst = ($urandom_range(0, 99) == 0);
      if (!p0_req && $urandom_range(0, 3) != 0)
        new0($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
      if (!p1_req && $urandom_range(0, 3) != 0)
        new1($urandom_range(0, 2) == 0, rand_addr(), $urandom());
      step();
    end
    in_rst = 0;
    repeat (6) step();
    @(negedge clk); #1;

    checks++;
    if (rq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d reads %0d grants outstanding want 0", rq.size(), gq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
